// File: rtl/seven_seg_capture_if.sv
// rtl/seven_seg_capture_if.sv - seven-segment display bus and recovered-digit outputs
// The master drives the display lines; the slave is the capture block.
interface seven_seg_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] bcd_digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    capture_pulse;
  logic                    err_pulse;
  logic                    frame_done;

  modport master (
    output seg_in,
    output dig_sel,
    input  bcd_digits,
    input  digit_valid,
    input  capture_pulse,
    input  err_pulse,
    input  frame_done
  );

  modport slave (
    input  seg_in,
    input  dig_sel,
    output bcd_digits,
    output digit_valid,
    output capture_pulse,
    output err_pulse,
    output frame_done
  );
endinterface

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - recovers BCD digits from a multiplexed seven-segment bus
// A digit is captured once {dig_sel, seg_in} has been identical for STABLE_CYCLES edges.
module seven_seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seven_seg_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

  state_t                  state, state_next;
  logic [7:0]              cnt, cnt_next;
  logic [NUM_DIGITS-1:0]   s_sel;
  logic [6:0]              s_seg;
  logic [NUM_DIGITS-1:0]   seen;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic                    cap_q, err_q, frame_q;

  logic                    sel_onehot;
  logic                    match;
  logic                    capture;
  logic                    dec_valid, dec_blank;
  logic [3:0]              dec_bcd;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Returns {valid, blank, bcd}; anything not in the table is neither.
  function automatic logic [5:0] decode(input logic [6:0] seg);
    logic [5:0] r;
    case (seg)
      7'b1111110: r = {2'b10, 4'd0};
      7'b0110000: r = {2'b10, 4'd1};
      7'b1101101: r = {2'b10, 4'd2};
      7'b1111001: r = {2'b10, 4'd3};
      7'b0110011: r = {2'b10, 4'd4};
      7'b1011011: r = {2'b10, 4'd5};
      7'b1011111: r = {2'b10, 4'd6};
      7'b1110000: r = {2'b10, 4'd7};
      7'b1111111: r = {2'b10, 4'd8};
      7'b1111011: r = {2'b10, 4'd9};
      7'b0000000: r = {2'b01, 4'd0};
      default:    r = {2'b00, 4'd0};
    endcase
    return r;
  endfunction

  assign sel_onehot = is_onehot(bus.dig_sel);
  assign match      = (bus.dig_sel == s_sel) && (bus.seg_in == s_seg);
  assign {dec_valid, dec_blank, dec_bcd} = decode(s_seg);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT: begin
        state_next = sel_onehot ? ST_COUNT : ST_WAIT;
      end
      ST_COUNT: begin
        if (match && sel_onehot)
          state_next = (cnt == LAST_CNT) ? ST_HELD : ST_COUNT;
        else
          state_next = sel_onehot ? ST_COUNT : ST_WAIT;
      end
      ST_HELD: begin
        if (!match)
          state_next = sel_onehot ? ST_COUNT : ST_WAIT;
      end
      default: state_next = ST_WAIT;
    endcase
  end

  // Output / counter logic; any broken dwell restarts the count on the new input.
  always_comb begin
    capture  = 1'b0;
    cnt_next = sel_onehot ? 8'd1 : 8'd0;
    case (state)
      ST_COUNT: begin
        if (match && sel_onehot) begin
          if (cnt == LAST_CNT) begin
            capture  = 1'b1;
            cnt_next = cnt;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
      end
      ST_HELD: begin
        if (match)
          cnt_next = cnt;
      end
      default: ;
    endcase
  end

  // Sample register and captured-digit datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sel   <= '0;
      s_seg   <= 7'd0;
      seen    <= '0;
      bcd_q   <= '0;
      valid_q <= '0;
      cap_q   <= 1'b0;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      s_sel   <= bus.dig_sel;
      s_seg   <= bus.seg_in;
      cap_q   <= capture;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
      if (capture) begin
        err_q <= !dec_valid && !dec_blank;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (s_sel[i]) begin
            valid_q[i] <= dec_valid;
            if (dec_valid)
              bcd_q[4*i +: 4] <= dec_bcd;
          end
        end
        // Completing the mask restarts it empty, current digit included.
        if (&(seen | s_sel)) begin
          frame_q <= 1'b1;
          seen    <= '0;
        end else begin
          seen    <= seen | s_sel;
        end
      end
    end
  end

  assign bus.bcd_digits    = bcd_q;
  assign bus.digit_valid   = valid_q;
  assign bus.capture_pulse = cap_q;
  assign bus.err_pulse     = err_q;
  assign bus.frame_done    = frame_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cap_cnt, err_cnt, fd_cnt, fd_digit;

  seven_seg_capture_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [0:9];
  initial begin
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101;
    pat[3] = 7'b1111001; pat[4] = 7'b0110011; pat[5] = 7'b1011011;
    pat[6] = 7'b1011111; pat[7] = 7'b1110000; pat[8] = 7'b1111111;
    pat[9] = 7'b1111011;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    cap_cnt = 0; err_cnt = 0; fd_cnt = 0; fd_digit = -1;
  endtask

  // One clock edge, sampled 1 time unit later; pulses are tallied.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (bus.capture_pulse) cap_cnt++;
      if (bus.err_pulse) err_cnt++;
      if (bus.frame_done) begin
        fd_cnt++;
        for (int d = 0; d < ND; d++)
          if (bus.dig_sel[d]) fd_digit = d;
      end
    end
  endtask

  initial begin
    bus.dig_sel = '0;
    bus.seg_in  = 7'd0;
    clear_counts();
    step(3);
    check("rst_bcd", 32'(bus.bcd_digits), 32'h0);
    check("rst_valid", 32'(bus.digit_valid), 32'h0);
    check("rst_pulses", {29'd0, bus.capture_pulse, bus.err_pulse, bus.frame_done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single digit 3 on digit 0, captured on the 4th edge only
    bus.dig_sel = 4'b0001; bus.seg_in = pat[3];
    step(3);
    check("t1_no_early_cap", 32'(cap_cnt), 32'd0);
    step(1);
    check("t1_cap_pulse", 32'(bus.capture_pulse), 32'd1);
    check("t1_nibble0", 32'(bus.bcd_digits[3:0]), 32'd3);
    check("t1_valid", 32'(bus.digit_valid), 32'b0001);
    check("t1_err", 32'(bus.err_pulse), 32'd0);
    clear_counts();
    step(10);
    check("t1_one_cap_per_dwell", 32'(cap_cnt), 32'd0);

    // Too-short dwell
    clear_counts();
    bus.dig_sel = 4'b0010; bus.seg_in = pat[4];
    step(3);
    bus.dig_sel = 4'b0000;
    step(2);
    check("t2_short_no_cap", 32'(cap_cnt), 32'd0);
    check("t2_valid1", 32'(bus.digit_valid[1]), 32'd0);

    // Full scan 1,2,3,4 on digits 0..3
    clear_counts();
    for (int d = 0; d < ND; d++) begin
      bus.dig_sel = 4'(1 << d); bus.seg_in = pat[d+1];
      step(5);
      bus.dig_sel = 4'b0000;
      step(1);
    end
    check("t3_bcd", 32'(bus.bcd_digits), 32'h4321);
    check("t3_valid", 32'(bus.digit_valid), 32'hf);
    check("t3_caps", 32'(cap_cnt), 32'd4);
    check("t3_frame_cnt", 32'(fd_cnt), 32'd1);
    check("t3_frame_digit", 32'(fd_digit), 32'd3);

    // Invalid pattern on digit 2, then blank on digit 1
    clear_counts();
    bus.dig_sel = 4'b0100; bus.seg_in = 7'b1000001;
    step(4);
    check("t4_err_pulse", 32'(bus.err_pulse), 32'd1);
    check("t4_err_cap", 32'(bus.capture_pulse), 32'd1);
    step(1);
    check("t4_err_one_cycle", 32'(bus.err_pulse), 32'd0);
    check("t4_valid2", 32'(bus.digit_valid), 32'b1011);
    check("t4_nibble2_kept", 32'(bus.bcd_digits), 32'h4321);
    bus.dig_sel = 4'b0000;
    step(1);
    clear_counts();
    bus.dig_sel = 4'b0010; bus.seg_in = 7'b0000000;
    step(5);
    check("t4_blank_cap", 32'(cap_cnt), 32'd1);
    check("t4_blank_no_err", 32'(err_cnt), 32'd0);
    check("t4_blank_valid", 32'(bus.digit_valid), 32'b1001);
    check("t4_blank_bcd", 32'(bus.bcd_digits), 32'h4321);

    // Multi-hot strobe and flickering segments never capture
    clear_counts();
    bus.dig_sel = 4'b0011; bus.seg_in = pat[8];
    step(8);
    check("t5_multihot", 32'(cap_cnt), 32'd0);
    bus.dig_sel = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      bus.seg_in = k[0] ? pat[9] : pat[8];
      step(2);
    end
    check("t5_toggle", 32'(cap_cnt), 32'd0);
    check("t5_err", 32'(err_cnt), 32'd0);

    // Reset in the middle of a dwell
    clear_counts();
    bus.dig_sel = 4'b0001; bus.seg_in = pat[5];
    step(2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_bcd", 32'(bus.bcd_digits), 32'h0);
    check("t6_rst_valid", 32'(bus.digit_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check("t6_partial_no_cap", 32'(cap_cnt), 32'd0);
    step(1);
    check("t6_cap", 32'(bus.capture_pulse), 32'd1);
    check("t6_nibble0", 32'(bus.bcd_digits), 32'h0005);
    check("t6_valid", 32'(bus.digit_valid), 32'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side companion to the team's BCD-to-seven-segment decoder.
- Monitors a time-multiplexed seven-segment display bus (segment lines plus one-hot digit strobes) and recovers the BCD value shown on each digit.
- Captures a digit only after its pattern has been stable for a programmable dwell, which rejects ghosting during strobe changes.
- Used for display loopback checking and for scraping panels driven by external controllers.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive clock edges an identical {dig_sel, seg_in} must be sampled before capture (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  7  segment lines, active-high (1 = lit), bit6..bit0 = a,b,c,d,e,f,g.
- dig_sel  in  NUM_DIGITS  one-hot digit strobe; bit i = digit i.
- bcd_digits  out  4*NUM_DIGITS  captured BCD; nibble i = bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  bit i = 1 when nibble i holds a decoded 0-9.
- capture_pulse  out  1  one-cycle pulse on every capture.
- err_pulse  out  1  one-cycle pulse when a captured pattern is neither a digit nor blank.
- frame_done  out  1  one-cycle pulse when every digit has been captured at least once since the last pulse.

Behaviour:
- Reset (async assert, sync release):
  - bcd_digits = 0, digit_valid = 0, all pulses = 0.
  - Internal: state = WAIT, cnt = 0, sample register = 0, seen mask = 0.
- Pattern table (seg_in -> BCD):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - 0000000 = blank. Any other pattern = invalid.
- Sampling: each edge registers {dig_sel, seg_in} into s_sel/s_seg. "Match" means the current input equals the registered value.
- States: WAIT, COUNT, HELD.
  - WAIT: if dig_sel is exactly one-hot, go to COUNT with cnt = 1; otherwise stay, cnt = 0.
  - COUNT: on match, cnt++. On the edge where a match occurs with cnt == STABLE_CYCLES-1, capture and go to HELD. On mismatch, or dig_sel not one-hot, reload: cnt = 1 and stay in COUNT if the new dig_sel is one-hot, else cnt = 0 and go to WAIT.
  - HELD: stay while matching (exactly one capture per dwell). On mismatch, behave as WAIT/COUNT entry using the new input.
- Capture latency: an input held stable starting before edge E1 is captured at edge E_STABLE_CYCLES. Outputs and pulses are registered and visible after that edge.
- Capture into digit i (the index of the s_sel bit):
  - Valid digit: nibble i = BCD, digit_valid[i] = 1.
  - Blank: nibble i unchanged, digit_valid[i] = 0, no error.
  - Invalid: nibble i unchanged, digit_valid[i] = 0, err_pulse = 1.
  - capture_pulse = 1 in all three cases.
- Zero-hot dig_sel (inter-digit blanking) and multi-hot dig_sel never capture and are not errors.
- frame_done:
  - seen[i] is set on any capture of digit i.
  - When a capture completes the mask (all ones including the current digit), frame_done pulses on the same edge as capture_pulse, and seen clears to 0 (the current bit is not retained).
  - Re-capturing a digit already in seen does not pulse.
- Other digits' nibbles and valid bits hold across captures.
- Reset mid-dwell discards the count; no capture and no pulses occur from a partial dwell.

Test Plan:
- Reset, then dig_sel=0001, seg_in=1111001 held 4 edges -> capture_pulse once on edge 4, nibble0=3, digit_valid=0001, err_pulse=0; hold 10 more edges -> no further pulses.
- dig_sel=0010, seg_in=0110011 held only 3 edges then dig_sel=0000 -> no capture, digit_valid[1]=0.
- Scan digits 0..3 showing 1,2,3,4 (5 edges each, 1 edge of dig_sel=0 between) -> bcd_digits=16'h4321, digit_valid=1111, frame_done pulses coincident with digit 3's capture only.
- Digit 2 with seg_in=1000001 held 4 edges -> err_pulse=1 one cycle, digit_valid[2]=0, nibble2 keeps its prior value 3; then blank 0000000 on digit 1 -> digit_valid[1]=0, err_pulse=0.
- dig_sel=0011 with seg_in=1111111 held 8 edges -> no capture; seg_in toggling between 8 and 9 every 2 edges on digit 0 -> no capture.
- rst_n asserted low for one cycle at edge 3 of a 4-edge dwell -> all outputs 0 immediately; re-held pattern needs 4 full edges after release before capture.
